// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding and fetch-stage PC defaults.
package cpu_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int PC_INC_DEF = 2;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;

  localparam logic [1:0] FS_RUN   = 2'd0;
  localparam logic [1:0] FS_MISS  = 2'd1;
  localparam logic [1:0] FS_REDIR = 2'd2;
  localparam logic [1:0] FS_HALT  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC controller: sequential fetch, ID redirects, redirect held across I-cache miss, HALT freeze.
// Optional perf counters are built when FETCH_PERF_EN is defined; otherwise the counter ports read 0.
//
// state      | meaning
// FS_RUN     | normal fetch, PC advances each unstalled cycle
// FS_MISS    | I-cache miss outstanding, PC holds
// FS_REDIR   | miss outstanding with a redirect queued in redir_q
// FS_HALT    | PC frozen until reset
module fetch_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              PC_INC   = PC_INC_DEF,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             imem_stall_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  branch_target_i,
  input  logic             halt_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus_o,
  output logic             fetch_valid_o,
  output logic             flush_ifid_o,
  output logic [CNT_W-1:0] redir_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [1:0]      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] redir_q;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_inc;
  logic            br;
  logic            flush_c;
  logic            active;

  // A redirect from a stalled ID stage is not yet real.
  assign br     = branch_taken_i & ~stall_i;
  assign tgt    = branch_target_i & ~PC_W'(1);
  assign pc_inc = pc_q + PC_W'(PC_INC);
  assign active = (state_q == FS_RUN) || (state_q == FS_MISS);

  always_comb begin
    flush_c = 1'b0;
    case (state_q)
      FS_RUN, FS_MISS: flush_c = br & ~imem_stall_i;
      FS_REDIR:        flush_c = ~imem_stall_i;
      default:         flush_c = 1'b0;
    endcase
  end

  assign pc_o          = pc_q;
  assign pc_plus_o     = pc_inc;
  assign flush_ifid_o  = rst_n & flush_c;
  assign fetch_valid_o = rst_n & active & ~imem_stall_i & ~flush_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      redir_q <= '0;
    end else begin
      case (state_q)
        FS_RUN, FS_MISS: begin
          if (br) begin
            // An outstanding miss cannot be aborted, so the target waits for it.
            if (imem_stall_i) begin
              redir_q <= tgt;
              state_q <= FS_REDIR;
            end else begin
              pc_q    <= tgt;
              state_q <= FS_RUN;
            end
          end else if (halt_i) begin
            state_q <= FS_HALT;
          end else if (stall_i) begin
            if (state_q == FS_MISS && !imem_stall_i)
              state_q <= FS_RUN;
          end else if (imem_stall_i) begin
            state_q <= FS_MISS;
          end else begin
            pc_q    <= pc_inc;
            state_q <= FS_RUN;
          end
        end
        FS_REDIR: begin
          if (!imem_stall_i) begin
            pc_q    <= br ? tgt : redir_q;
            state_q <= FS_RUN;
          end else if (br) begin
            redir_q <= tgt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic not_halted;
  assign not_halted = (state_q != FS_HALT);

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br & not_halted),
    .cnt   (redir_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (imem_stall_i & not_halted),
    .cnt   (stall_cnt_o)
  );
`else
  assign redir_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: vector table plus hand-written corner sequences, expectations via a queue.
module tb_fetch_redirect_ctrl;

  typedef struct {
    logic        stall;
    logic        imem;
    logic        br;
    logic [15:0] tgt;
    logic        halt;
    logic [15:0] pc;
    logic        flush;
    logic        valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        imem_stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [15:0] branch_target_i = 16'h0;
  logic        halt_i = 1'b0;
  logic [15:0] pc_o, pc_plus_o, redir_cnt_o, stall_cnt_o;
  logic        fetch_valid_o, flush_ifid_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_redir = 16'h0;
  logic [15:0] m_stall = 16'h0;
  vec_t sb_q[$];
  vec_t tbl[30];

  fetch_redirect_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .imem_stall_i    (imem_stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .pc_o            (pc_o),
    .pc_plus_o       (pc_plus_o),
    .fetch_valid_o   (fetch_valid_o),
    .flush_ifid_o    (flush_ifid_o),
    .redir_cnt_o     (redir_cnt_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic im, logic b, logic [15:0] t, logic h,
                              logic [15:0] p, logic f, logic v);
    vec_t r;
    r.stall = s; r.imem = im; r.br = b; r.tgt = t; r.halt = h;
    r.pc = p; r.flush = f; r.valid = v;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, check pre-edge outputs, update counter model, advance to next negedge.
  task automatic step(input vec_t v, input bit halted);
    vec_t e;
    stall_i = v.stall; imem_stall_i = v.imem; branch_taken_i = v.br;
    branch_target_i = v.tgt; halt_i = v.halt;
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    chk("pc_o", pc_o, e.pc);
    chk("pc_plus_o", pc_plus_o, e.pc + 16'd2);
    chk("flush_ifid_o", {15'd0, flush_ifid_o}, {15'd0, e.flush});
    chk("fetch_valid_o", {15'd0, fetch_valid_o}, {15'd0, e.valid});
    chk("redir_cnt_o", redir_cnt_o, m_redir);
    chk("stall_cnt_o", stall_cnt_o, m_stall);
`ifdef FETCH_PERF_EN
    if (!halted) begin
      if (e.br && !e.stall && m_redir != 16'hFFFF) m_redir++;
      if (e.imem && m_stall != 16'hFFFF) m_stall++;
    end
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 0; imem_stall_i = 0; branch_taken_i = 0; branch_target_i = 0; halt_i = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst pc_o", pc_o, 16'h0000);
    chk("rst fetch_valid_o", {15'd0, fetch_valid_o}, 16'd0);
    chk("rst flush_ifid_o", {15'd0, flush_ifid_o}, 16'd0);
    chk("rst redir_cnt_o", redir_cnt_o, 16'd0);
    chk("rst stall_cnt_o", stall_cnt_o, 16'd0);
    m_redir = 0; m_stall = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    // stall imem br tgt halt | pc flush valid
    tbl[0]  = mk(0,0,0,16'h0000,0, 16'h0000,0,1);
    tbl[1]  = mk(0,0,0,16'h0000,0, 16'h0002,0,1);
    tbl[2]  = mk(0,0,0,16'h0000,0, 16'h0004,0,1);
    tbl[3]  = mk(0,0,0,16'h0000,0, 16'h0006,0,1);
    tbl[4]  = mk(0,0,0,16'h0000,0, 16'h0008,0,1);
    tbl[5]  = mk(0,0,0,16'h0000,0, 16'h000A,0,1);
    tbl[6]  = mk(0,0,0,16'h0000,0, 16'h000C,0,1);
    tbl[7]  = mk(0,0,0,16'h0000,0, 16'h000E,0,1);
    tbl[8]  = mk(0,0,1,16'h0040,0, 16'h0010,1,0);
    tbl[9]  = mk(0,0,0,16'h0000,0, 16'h0040,0,1);
    tbl[10] = mk(0,0,1,16'h0021,0, 16'h0042,1,0);
    tbl[11] = mk(0,1,0,16'h0000,0, 16'h0020,0,0);
    tbl[12] = mk(0,1,1,16'h0100,0, 16'h0020,0,0);
    tbl[13] = mk(0,1,0,16'h0000,0, 16'h0020,0,0);
    tbl[14] = mk(0,0,0,16'h0000,0, 16'h0020,1,0);
    tbl[15] = mk(0,0,0,16'h0000,0, 16'h0100,0,1);
    tbl[16] = mk(0,1,0,16'h0000,0, 16'h0102,0,0);
    tbl[17] = mk(0,1,0,16'h0000,0, 16'h0102,0,0);
    tbl[18] = mk(0,0,0,16'h0000,0, 16'h0102,0,1);
    tbl[19] = mk(0,0,0,16'h0000,0, 16'h0104,0,1);
    tbl[20] = mk(1,0,1,16'h0200,0, 16'h0106,0,1);
    tbl[21] = mk(1,0,1,16'h0200,0, 16'h0106,0,1);
    tbl[22] = mk(0,0,1,16'h0200,0, 16'h0106,1,0);
    tbl[23] = mk(0,0,0,16'h0000,0, 16'h0200,0,1);
    tbl[24] = mk(1,0,0,16'h0000,0, 16'h0202,0,1);
    tbl[25] = mk(0,0,0,16'h0000,0, 16'h0202,0,1);
    tbl[26] = mk(0,1,1,16'h0300,0, 16'h0204,0,0);
    tbl[27] = mk(0,1,1,16'h0400,0, 16'h0204,0,0);
    tbl[28] = mk(0,0,0,16'h0000,0, 16'h0204,1,0);
    tbl[29] = mk(0,0,0,16'h0000,0, 16'h0400,0,1);

    do_reset();
    for (int i = 0; i < 30; i++) step(tbl[i], 1'b0);

    // HALT at 0030: frozen, redirects and misses ignored, counters idle.
    do_reset();
    for (int i = 0; i < 24; i++)
      step(mk(0,0,0,16'h0,0, 16'(i*2),0,1), 1'b0);
    step(mk(0,0,0,16'h0,1, 16'h0030,0,1), 1'b0);
    for (int i = 0; i < 10; i++)
      step(mk(0,i[0],1,16'h1234,0, 16'h0030,0,0), 1'b1);

    // Reset pulse out of HALT, then wrap at FFFE.
    do_reset();
    step(mk(0,0,1,16'hFFFE,0, 16'h0000,1,0), 1'b0);
    step(mk(0,0,0,16'h0000,0, 16'hFFFE,0,1), 1'b0);
    step(mk(0,0,0,16'h0000,0, 16'h0000,0,1), 1'b0);

    // Redirects queued behind an endless miss drive both counters.
`ifdef FETCH_PERF_EN
    for (int i = 0; i < 65540; i++)
      step(mk(0,1,1,16'h0010,0, 16'h0002,0,0), 1'b0);
    chk("redir_cnt_o sat", redir_cnt_o, 16'hFFFF);
    chk("stall_cnt_o sat", stall_cnt_o, 16'hFFFF);
`else
    for (int i = 0; i < 4; i++)
      step(mk(0,1,1,16'h0010,0, 16'h0002,0,0), 1'b0);
`endif

    // Reset while a redirect is pending: target lost.
    rst_n = 1'b0;
    #1;
    chk("rst mid-pend pc_o", pc_o, 16'h0000);
    chk("rst mid-pend flush", {15'd0, flush_ifid_o}, 16'd0);
    @(negedge clk);
    m_redir = 0; m_stall = 0;
    stall_i = 0; imem_stall_i = 0; branch_taken_i = 0; halt_i = 0;
    rst_n = 1'b1;
    step(mk(0,0,0,16'h0,0, 16'h0000,0,1), 1'b0);
    step(mk(0,0,0,16'h0,0, 16'h0002,0,1), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
